led_matrix_scan_ctrl: RTL and testbench

LED_MATRIX_SCAN_CTRL -- requirements
Module: led_matrix_scan_ctrl

---
 rtl/maze_pkg.sv | 25 ++
 rtl/scan_prescaler.sv | 26 ++
 rtl/led_matrix_scan_ctrl.sv | 117 +++++++++++
 tb/tb_led_matrix_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze display geometry, cursor layout and scan FSM state encoding.
// Pure declarations; no timing or flow-control behaviour of its own.
package maze_pkg;
  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int FRAME_W   = ROWS * COLS;
  localparam int ROW_IDX_W = 3;
  localparam int COL_IDX_W = 3;
  localparam int CURSOR_W  = ROW_IDX_W + COL_IDX_W;

  typedef struct packed {
    logic [ROW_IDX_W-1:0] row;
    logic [COL_IDX_W-1:0] col;
  } cursor_t;

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  function automatic logic [COLS-1:0] frame_row(input logic [FRAME_W-1:0] frame,
                                                input logic [ROW_IDX_W-1:0] idx);
    return frame[idx*COLS +: COLS];
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// Row-dwell prescaler: tick pulses once every TICK_DIV cycles, combinational from the count.
// hold clears the count and suppresses tick; the next tick comes TICK_DIV cycles after release.
module scan_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);
  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = ~hold & (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || hold) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// 8x8 LED matrix row scanner with double-buffered frames and a blinking cursor overlay.
// Row/col registered one edge after tick; frame_ready drops while a frame waits for the next boundary.
module led_matrix_scan_ctrl
  import maze_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [FRAME_W-1:0]  frame_in,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic [CURSOR_W-1:0] cursor,
  input  logic                cursor_en,
  input  logic                blank,
  output logic [ROWS-1:0]     row,
  output logic [COLS-1:0]     col,
  output logic                frame_sync
);
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  scan_state_t          state, state_next;
  logic [FRAME_W-1:0]   active, pending;
  logic                 pending_full;
  logic [ROW_IDX_W-1:0] idx;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_phase;
  logic                 tick, blanking, boundary, swap, sync_next, accept;
  logic [COLS-1:0]      col_pix;
  cursor_t              cur;

  assign cur         = cursor_t'(cursor);
  assign frame_ready = ~pending_full;
  assign accept      = frame_valid & frame_ready;

  scan_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .hold  (blanking),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCAN;
    end else begin
      state <= state_next;
    end
  end

  // Blank takes effect on the edge that first samples it, so everything keys off state_next.
  always_comb begin
    state_next = state;
    case (state)
      SCAN:    if (blank)  state_next = BLANK;
      BLANK:   if (!blank) state_next = SCAN;
      default: state_next = SCAN;
    endcase
    blanking  = (state_next == BLANK);
    boundary  = tick & ~blanking & (idx == ROW_IDX_W'(ROWS - 1));
    swap      = pending_full & (boundary | blanking);
    sync_next = boundary | swap;
  end

  always_comb begin
    col_pix = frame_row(active, idx);
    if (cursor_en && blink_phase && (idx == cur.row)) begin
      col_pix[cur.col] = ~col_pix[cur.col];
    end
  end

  // accept needs pending empty and swap needs it full, so the two never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      frame_sync   <= 1'b0;
    end else begin
      frame_sync <= sync_next;
      if (accept) begin
        pending      <= frame_in;
        pending_full <= 1'b1;
      end else if (swap) begin
        active       <= pending;
        pending_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || blanking) begin
      row <= '1;
      col <= '0;
      idx <= '0;
    end else if (tick) begin
      row <= ~(ROWS'(1) << idx);
      col <= col_pix;
      idx <= idx + ROW_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (boundary) begin
      if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Scoreboard bench for led_matrix_scan_ctrl (TICK_DIV=4, BLINK_FRAMES=2): expected row/col
// events and frame_sync cycles are queued at stimulus time and popped by a negedge monitor.
module tb_led_matrix_scan_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [5:0]  cursor;
  logic        cursor_en;
  logic        blank;
  logic [7:0]  row;
  logic [7:0]  col;
  logic        frame_sync;

  localparam logic [63:0] F1 = 64'h0102040810204080;
  localparam logic [63:0] F2 = 64'h8040201008040201;
  localparam logic [63:0] F3 = 64'h1122334455667788;
  localparam logic [63:0] F4 = 64'h0807060504030201;
  localparam logic [63:0] F5 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] F6 = 64'hFFFFFFFFFFFFFFFF;

  typedef struct {
    int         cyc;
    logic [7:0] row;
    logic [7:0] col;
  } exp_t;

  exp_t     row_q[$];
  int       sync_q[$];
  exp_t     mon_e;
  int       mon_s;
  int       total = 0;
  int       bad   = 0;
  int       cyc   = 0;
  logic     mon_on = 1'b0;
  logic [7:0] prev_row = 8'hFF;

  led_matrix_scan_ctrl #(.TICK_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .cursor      (cursor),
    .cursor_en   (cursor_en),
    .blank       (blank),
    .row         (row),
    .col         (col),
    .frame_sync  (frame_sync)
  );

  always #5 clk = ~clk;

  // cyc == k just after the k-th edge that samples reset low
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (row !== prev_row) begin
        total++;
        if (row_q.size() == 0) begin
          bad++;
          $display("FAIL row_event unexpected: got cyc=%0d row=%h col=%h", cyc, row, col);
        end else begin
          mon_e = row_q.pop_front();
          if (cyc !== mon_e.cyc || row !== mon_e.row || col !== mon_e.col) begin
            bad++;
            $display("FAIL row_event: got cyc=%0d row=%h col=%h, want cyc=%0d row=%h col=%h",
                     cyc, row, col, mon_e.cyc, mon_e.row, mon_e.col);
          end
        end
      end
      prev_row = row;
      if (frame_sync !== 1'b0) begin
        total++;
        if (sync_q.size() == 0) begin
          bad++;
          $display("FAIL frame_sync unexpected: got cyc=%0d value=%b", cyc, frame_sync);
        end else begin
          mon_s = sync_q.pop_front();
          if (cyc !== mon_s || frame_sync !== 1'b1) begin
            bad++;
            $display("FAIL frame_sync: got cyc=%0d value=%b, want cyc=%0d value=1",
                     cyc, frame_sync, mon_s);
          end
        end
      end
    end
  end

  task automatic push_ev(input int c, input logic [7:0] r, input logic [7:0] cl);
    exp_t e;
    e.cyc = c;
    e.row = r;
    e.col = cl;
    row_q.push_back(e);
  endtask

  // Rows of one frame land every 4 cycles; r3x is the cursor overlay expected on row 3.
  task automatic push_frame(input int start, input logic [63:0] fr, input int nrows,
                            input logic [7:0] r3x);
    for (int r = 0; r < nrows; r++) begin
      push_ev(start + 4 * r, ~(8'd1 << r), fr[8*r +: 8] ^ ((r == 3) ? r3x : 8'h00));
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic at_edge(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_row"}, row, 8'hFF);
    chk({tag, "_col"}, col, 8'h00);
    chk({tag, "_frame_ready"}, {7'd0, frame_ready}, 8'h01);
    chk({tag, "_frame_sync"}, {7'd0, frame_sync}, 8'h00);
  endtask

  initial begin
    reset       = 1'b1;
    frame_in    = '0;
    frame_valid = 1'b0;
    cursor      = '0;
    cursor_en   = 1'b0;
    blank       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_on = 1'b1;

    // Double buffering: F1 shows in frame 1, F2 waits for the boundary and shows in frames 2-3.
    push_frame(4, 64'd0, 8, 8'h00);
    push_frame(36, F1, 8, 8'h00);
    push_frame(68, F2, 8, 8'h00);
    push_frame(100, F2, 8, 8'h00);
    sync_q.push_back(32); sync_q.push_back(64); sync_q.push_back(96); sync_q.push_back(128);
    at_edge(1);
    frame_valid = 1'b1;
    frame_in    = F1;
    at_edge(2);
    frame_in = F2;
    @(negedge clk);
    chk("ready_while_pending", {7'd0, frame_ready}, 8'h00);
    at_edge(32);
    @(negedge clk);
    chk("ready_after_swap", {7'd0, frame_ready}, 8'h01);
    at_edge(33);
    frame_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_second_accept", {7'd0, frame_ready}, 8'h00);

    // Accept on the idx==7 tick edge: F3 skips frame 3 and appears in frame 4.
    at_edge(95);
    push_frame(132, F3, 8, 8'h00);
    sync_q.push_back(160);
    frame_valid = 1'b1;
    frame_in    = F3;
    at_edge(96);
    frame_valid = 1'b0;
    @(negedge clk);
    chk("ready_coincident_accept", {7'd0, frame_ready}, 8'h00);

    // Cursor blink over an all-zero frame: row 3 col 5 lit in phase-1 frames 6-7 only.
    at_edge(129);
    push_frame(164, 64'd0, 8, 8'h00);
    push_frame(196, 64'd0, 8, 8'h20);
    push_frame(228, 64'd0, 8, 8'h20);
    push_frame(260, 64'd0, 8, 8'h00);
    push_frame(292, 64'd0, 8, 8'h00);
    sync_q.push_back(192); sync_q.push_back(224); sync_q.push_back(256);
    sync_q.push_back(288); sync_q.push_back(320);
    frame_valid = 1'b1;
    frame_in    = 64'd0;
    at_edge(130);
    frame_valid = 1'b0;
    at_edge(160);
    cursor    = 6'b011_101;
    cursor_en = 1'b1;
    at_edge(320);
    cursor_en = 1'b0;

    // Blank mid-frame with F4 pending: immediate swap, resume at row 0 four cycles after release.
    at_edge(321);
    push_frame(324, 64'd0, 3, 8'h00);
    push_ev(334, 8'hFF, 8'h00);
    push_frame(344, F4, 8, 8'h00);
    push_frame(376, F4, 2, 8'h00);
    sync_q.push_back(334); sync_q.push_back(372);
    frame_valid = 1'b1;
    frame_in    = F4;
    at_edge(322);
    frame_valid = 1'b0;
    at_edge(333);
    blank = 1'b1;
    at_edge(334);
    @(negedge clk);
    chk("ready_after_blank_swap", {7'd0, frame_ready}, 8'h01);
    at_edge(340);
    blank = 1'b0;

    // Reset mid-frame with F5 pending and F6 offered on the reset edge: both discarded.
    at_edge(373);
    frame_valid = 1'b1;
    frame_in    = F5;
    at_edge(374);
    frame_valid = 1'b0;
    @(negedge clk);
    chk("ready_before_reset", {7'd0, frame_ready}, 8'h00);
    at_edge(381);
    push_ev(0, 8'hFF, 8'h00);
    push_frame(4, 64'd0, 8, 8'h00);
    push_frame(36, 64'd0, 8, 8'h00);
    push_frame(68, 64'd0, 8, 8'h20);
    sync_q.push_back(32); sync_q.push_back(64); sync_q.push_back(96);
    reset       = 1'b1;
    frame_valid = 1'b1;
    frame_in    = F6;
    cursor      = 6'b011_101;
    cursor_en   = 1'b1;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    @(negedge clk);
    reset_checks("midrun_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    at_edge(97);
    @(negedge clk);
    chk("row_queue_drained", 8'(row_q.size()), 8'h00);
    chk("sync_queue_drained", 8'(sync_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
